mux_arb_n: RTL

MUX_ARB_N -- requirements
Module: mux_arb_n

---
 rtl/mux_arb_n.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mux_arb_n.sv
// mux_arb_n: N-channel valid/ready multiplexer with a registered output stage.
// Each cycle one channel is granted, either the fixed index on sel or a
// round-robin choice. The granted beat is captured into out_data/out_ch.
// Optional feature: define MUX_ARB_LOCK_EN to add in_last[] packet locking.
// With locking enabled, the grant stays on one channel until that channel
// sends a beat with in_last set.
module mux_arb_n #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          in_valid,
`ifdef MUX_ARB_LOCK_EN
    input  logic [N_CH-1:0]          in_last,
`endif
    output logic [N_CH-1:0]          in_ready,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEL_W-1:0]         out_ch
);

    // Output stage and round-robin pointer.
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] outData_q, outData_d;
    logic [SEL_W-1:0]  outCh_q, outCh_d;
    logic              outValid_q, outValid_d;

    // Arbitration results.
    logic              grantValid;
    logic [SEL_W-1:0]  grantIdx;
    logic [DATA_W-1:0] grantData;
    logic              grantLast;
    logic [N_CH-1:0]   grantOneHot;
    logic              canAccept;
    logic              inXfer;

    // Lock view seen by the arbiter. This is tied off when locking is not built.
    logic              lockActive;
    logic [SEL_W-1:0]  lockCh;

`ifdef MUX_ARB_LOCK_EN
    logic              lockActive_q, lockActive_d;
    logic [SEL_W-1:0]  lockCh_q, lockCh_d;

    assign lockActive = lockActive_q;
    assign lockCh     = lockCh_q;
`else
    assign lockActive = 1'b0;
    assign lockCh     = '0;
`endif

    // Pick the granted channel: a held lock wins, then fixed select or round-robin search.
    always_comb begin
        logic [SEL_W:0] sum;
        grantValid = 1'b0;
        grantIdx   = '0;
        sum        = '0;
        if (lockActive) begin
            grantValid = 1'b1;
            grantIdx   = lockCh;
        end else if (!mode) begin
            if ({1'b0, sel} < (SEL_W+1)'(N_CH)) begin
                grantValid = 1'b1;
                grantIdx   = sel;
            end
        end else begin
            for (int k = 1; k <= N_CH; k++) begin
                sum = {1'b0, ptr_q} + (SEL_W+1)'(k);
                if (sum >= (SEL_W+1)'(N_CH)) begin
                    sum = sum - (SEL_W+1)'(N_CH);
                end
                if (!grantValid && in_valid[sum[SEL_W-1:0]]) begin
                    grantValid = 1'b1;
                    grantIdx   = sum[SEL_W-1:0];
                end
            end
        end
    end

    // Decode the grant into a one-hot vector and mux out that channel's data and last flag.
    always_comb begin
        grantOneHot = '0;
        grantData   = '0;
        grantLast   = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (grantIdx == SEL_W'(i)) begin
                grantOneHot[i] = 1'b1;
                grantData      = in_data[i*DATA_W +: DATA_W];
`ifdef MUX_ARB_LOCK_EN
                grantLast      = in_last[i];
`endif
            end
        end
    end

    // Accept only when the output slot is free or draining this cycle. Reset also blocks acceptance.
    always_comb begin
        canAccept = !outValid_q || out_ready;
        in_ready  = (grantValid && canAccept && rst_n) ? grantOneHot : '0;
        inXfer    = |(in_valid & in_ready);
    end

    // Next state: load on an input transfer, otherwise drain the slot on an output transfer.
    always_comb begin
        ptr_d      = ptr_q;
        outData_d  = outData_q;
        outCh_d    = outCh_q;
        outValid_d = outValid_q;
        if (inXfer) begin
            ptr_d      = grantIdx;
            outData_d  = grantData;
            outCh_d    = grantIdx;
            outValid_d = 1'b1;
        end else if (out_ready) begin
            outValid_d = 1'b0;
        end
    end

    // Output stage and pointer registers. ptr resets to the last channel so the search starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= SEL_W'(N_CH - 1);
            outData_q  <= '0;
            outCh_q    <= '0;
            outValid_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            outData_q  <= outData_d;
            outCh_q    <= outCh_d;
            outValid_q <= outValid_d;
        end
    end

`ifdef MUX_ARB_LOCK_EN
    // Lock next state: every accepted beat decides whether the grant stays on its channel.
    always_comb begin
        lockActive_d = lockActive_q;
        lockCh_d     = lockCh_q;
        if (inXfer) begin
            lockActive_d = !grantLast;
            lockCh_d     = grantIdx;
        end
    end

    // Lock registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lockActive_q <= 1'b0;
            lockCh_q     <= '0;
        end else begin
            lockActive_q <= lockActive_d;
            lockCh_q     <= lockCh_d;
        end
    end
`endif

    assign out_data  = outData_q;
    assign out_ch    = outCh_q;
    assign out_valid = outValid_q;

endmodule
